fpu_dot_seq: RTL and testbench
==============================

# fpu_dot_seq

Sequential bfloat16 dot-product sequencer that sits directly upstream of the combinational `fpu` and consumes its result. It accepts a stream of operand pairs over a valid/ready handshake and drives one shared `fpu` instance, multiply first and then accumulate. It returns the sum of products and a sticky overflow flag when the element marked last has been folded in. This turns the single-shot `fpu` into a reusable streaming datapath stage.

## Interface
- `CNT_W`, default 8: width of the element counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  operand pair valid.
- `in_ready_o`  out  1  block can accept an operand pair.
- `in_a_i`  in  16  bfloat16 operand A.
- `in_b_i`  in  16  bfloat16 operand B.
- `in_last_i`  in  1  this pair is the final element of the vector.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `out_data_o`  out  16  bfloat16 accumulated result.
- `out_overflow_o`  out  1  sticky OR of `fpu_overflow_i` over the vector.
- `out_count_o`  out  CNT_W  number of elements accumulated; saturates at all-ones.
- `fpu_mode_o`  out  4  one-hot mode to the fpu: 0001 add, 0010 sub, 0100 mul, 1000 div.
- `fpu_in1_o`, `fpu_in2_o`  out  16  fpu operands.
- `fpu_out_i`  in  16  fpu result, which is combinational from `fpu_*_o`.
- `fpu_overflow_i`  in  1  fpu overflow for the current operation.

## Operation
- The FSM has four states: LOAD, MUL, ADD, DONE. Reset state is LOAD.
- **LOAD**
  - `in_ready_o`=1.
  - `fpu_mode_o`=0000 and `fpu_in1_o`=`fpu_in2_o`=16'h0000.
  - On `in_valid_i && in_ready_o`, latch A, B and last, then go to MUL.
  - With no valid, stay in LOAD and keep the accumulator.
- **MUL**
  - `fpu_mode_o`=0100, `fpu_in1_o`=A, `fpu_in2_o`=B.
  - At the edge: product register ← captured `fpu_out_i`; ovf ← ovf | `fpu_overflow_i`. Go to ADD.
- **ADD**
  - `fpu_mode_o`=0001, `fpu_in1_o`=acc, `fpu_in2_o`=product.
  - At the edge: acc ← captured `fpu_out_i`; ovf |= `fpu_overflow_i`; count ← count+1, saturating.
  - Next state is DONE if last was set, else LOAD.
- **DONE**
  - `out_valid_o`=1; `out_data_o`=acc and `out_overflow_o`=ovf are held stable.
  - `fpu_mode_o`=0000 and fpu operands are 0.
  - On `out_ready_i`: clear acc to 16'h0000, ovf to 0 and count to 0, then go to LOAD.
- `in_ready_o` is 0 in MUL, ADD and DONE. `out_valid_o` is 1 only in DONE.
- `out_data_o`, `out_overflow_o` and `out_count_o` are registered and reflect acc/ovf/count in every state. They are valid to the consumer only while `out_valid_o`=1.
- The accumulator starts at +0, so the first ADD returns the product unchanged.
- The `fpu_mode_o` encoding matches `fpu` exactly. Sub and div are never issued.

## Timing
- Reset values:
  - state LOAD, `in_ready_o`=1, `out_valid_o`=0.
  - `out_data_o`=16'h0000, `out_overflow_o`=0, `out_count_o`=0.
  - `fpu_mode_o`=0000, `fpu_in1_o`=`fpu_in2_o`=16'h0000.
- Throughput is 3 cycles per element: LOAD, MUL, ADD.
- The accept edge for the last pair is E0. `out_valid_o` rises after E0+2 cycles, i.e. the same edge at which ADD completes.
- Back-to-back vectors: the LOAD accept can occur on the edge after the DONE handshake edge, never on the same edge.
- `fpu_out_i` is sampled in the same cycle its operands are driven. The fpu path must meet one cycle.
- Reset asserted mid-operation:
  - all registers clear immediately; the partial vector is discarded.
  - no `out_valid_o` is produced for it.
- `out_ready_i` held low: DONE persists indefinitely and all outputs stay stable.
- Count saturation: after 2^CNT_W−1 elements the count stays at all-ones. Accumulation continues.

## Configuration
- `FPU_DOT_SAT_EN` defined: when `fpu_overflow_i`=1 at a MUL or ADD capture, the captured value is replaced.
  - Replacement is signed max finite: 16'h7F7F if `fpu_out_i[15]`=0, else 16'hFF7F.
- `FPU_DOT_SAT_EN` undefined: the raw `fpu_out_i` is captured.
- `out_overflow_o` is sticky in both builds.

## Test plan
- **Two-element vector.** Pairs (3F80,4000) then (4000,4040, last) → `out_data_o`=4100 (8.0), `out_count_o`=2, overflow 0, `out_valid_o` 2 cycles after the last accept edge.
- **Single element.** (4040,4080, last) → 4140 (12.0), count 1. `fpu_mode_o` sequence is 0000, 0100, 0001, 0000.
- **Output backpressure.** Hold `out_ready_i`=0 for 5 cycles in DONE → outputs stable and `in_ready_o`=0. Assert `out_ready_i` → next cycle LOAD, acc=0000.
- **Overflow.** (7F00,7F00, last) → `out_overflow_o`=1. With `FPU_DOT_SAT_EN`, `out_data_o`=7F7F.
- **Reset mid-vector.** Deassert `rst_ni` during ADD of element 1 of 3 → all outputs at reset values immediately. A following single-pair vector (3F80,3F80, last) yields 3F80 with count 1.
- **Idle input.** `in_valid_i`=0 for 10 cycles in LOAD → `in_ready_o` stays 1, `fpu_mode_o`=0000, no state change.

Source files
------------

// File: rtl/fpu_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dot_seq
// Description : Streaming bfloat16 dot-product sequencer. Accepts operand
//               pairs over valid/ready, drives one shared combinational fpu
//               (multiply, then accumulate) and returns the sum of products
//               with a sticky overflow flag once the last element is folded.
//               Optional build macro FPU_DOT_SAT_EN: when defined, an fpu
//               result flagged as overflow is replaced by the signed maximum
//               finite bfloat16 before it is captured.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_dot_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // operand stream
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_a_i,
  input  logic [15:0]      in_b_i,
  input  logic             in_last_i,
  // result stream
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic             out_overflow_o,
  output logic [CNT_W-1:0] out_count_o,
  // shared fpu
  output logic [3:0]       fpu_mode_o,
  output logic [15:0]      fpu_in1_o,
  output logic [15:0]      fpu_in2_o,
  input  logic [15:0]      fpu_out_i,
  input  logic             fpu_overflow_i
);

  // FSM encoding
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // one-hot fpu modes (sub 0010 and div 1000 are never issued)
  localparam logic [3:0] MODE_IDLE = 4'b0000;
  localparam logic [3:0] MODE_ADD  = 4'b0001;
  localparam logic [3:0] MODE_MUL  = 4'b0100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             last_q, last_d;
  logic [15:0]      prod_q, prod_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic [15:0]      fpu_capture;

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  // state register; reset abandons any partial vector
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: LOAD -> MUL -> ADD -> (LOAD | DONE), DONE waits for consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (in_fire)  state_d = ST_MUL;
      ST_MUL:                state_d = ST_ADD;
      ST_ADD:                state_d = last_q ? ST_DONE : ST_LOAD;
      ST_DONE: if (out_fire) state_d = ST_LOAD;
      default:               state_d = ST_LOAD;
    endcase
  end

  // output decode: handshakes and fpu operand steering per state
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    fpu_mode_o  = MODE_IDLE;
    fpu_in1_o   = 16'h0000;
    fpu_in2_o   = 16'h0000;
    case (state_q)
      ST_LOAD: begin
        in_ready_o = 1'b1;
      end
      ST_MUL: begin
        fpu_mode_o = MODE_MUL;
        fpu_in1_o  = a_q;
        fpu_in2_o  = b_q;
      end
      ST_ADD: begin
        fpu_mode_o = MODE_ADD;
        fpu_in1_o  = acc_q;
        fpu_in2_o  = prod_q;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

`ifdef FPU_DOT_SAT_EN
  // clamp an overflowing fpu result to the signed largest finite bfloat16
  always_comb begin
    fpu_capture = fpu_out_i;
    if (fpu_overflow_i) begin
      fpu_capture = fpu_out_i[15] ? 16'hFF7F : 16'h7F7F;
    end
  end
`else
  // capture the fpu result exactly as produced
  always_comb begin
    fpu_capture = fpu_out_i;
  end
`endif

  // datapath next-state: operand latch, product/accumulator capture, counter
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    last_d = last_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          a_d    = in_a_i;
          b_d    = in_b_i;
          last_d = in_last_i;
        end
      end
      ST_MUL: begin
        prod_d = fpu_capture;
        ovf_d  = ovf_q | fpu_overflow_i;
      end
      ST_ADD: begin
        acc_d = fpu_capture;
        ovf_d = ovf_q | fpu_overflow_i;
        // count sticks at all-ones while accumulation carries on
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
      ST_DONE: begin
        // result consumed: start the next vector from +0
        if (out_fire) begin
          acc_d = 16'h0000;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      last_q <= 1'b0;
      prod_q <= 16'h0000;
      acc_q  <= 16'h0000;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      last_q <= last_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data_o     = acc_q;
  assign out_overflow_o = ovf_q;
  assign out_count_o    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_dot_seq
// Description : Directed self-checking bench for fpu_dot_seq. The fpu is a
//               small lookup model holding hand-computed bfloat16 results for
//               the operand pairs used below.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_dot_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;
  logic [3:0]       fpu_mode;
  logic [15:0]      fpu_in1;
  logic [15:0]      fpu_in2;
  logic [15:0]      fpu_out;
  logic             fpu_ovf;

  int tests = 0;
  int fails = 0;

`ifdef FPU_DOT_SAT_EN
  localparam logic [15:0] OVF_RESULT = 16'h7F7F;
`else
  localparam logic [15:0] OVF_RESULT = 16'h7F80;
`endif

  always #5 clk = ~clk;

  fpu_dot_seq #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .in_last_i      (in_last),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_overflow_o (out_ovf),
    .out_count_o    (out_count),
    .fpu_mode_o     (fpu_mode),
    .fpu_in1_o      (fpu_in1),
    .fpu_in2_o      (fpu_in2),
    .fpu_out_i      (fpu_out),
    .fpu_overflow_i (fpu_ovf)
  );

  // fpu lookup model with hand-computed bfloat16 results
  always_comb begin
    fpu_out = 16'h0000;
    fpu_ovf = 1'b0;
    case (fpu_mode)
      4'b0100: begin
        if (fpu_in1 == 16'h0000 || fpu_in2 == 16'h0000) fpu_out = 16'h0000;
        else if (fpu_in1 == 16'h3F80) fpu_out = fpu_in2;   // 1.0 * x
        else if (fpu_in2 == 16'h3F80) fpu_out = fpu_in1;   // x * 1.0
        else begin
          case ({fpu_in1, fpu_in2})
            32'h4000_4040: fpu_out = 16'h40C0;                   // 2*3 = 6
            32'h4040_4080: fpu_out = 16'h4140;                   // 3*4 = 12
            32'h7F00_7F00: begin fpu_out = 16'h7F80; fpu_ovf = 1'b1; end
            default:       fpu_out = 16'hFFFF;
          endcase
        end
      end
      4'b0001: begin
        if (fpu_in1 == 16'h0000) fpu_out = fpu_in2;
        else if (fpu_in2 == 16'h0000) fpu_out = fpu_in1;
        else if ({fpu_in1, fpu_in2} == 32'h4000_40C0) fpu_out = 16'h4100; // 2+6 = 8
        else fpu_out = 16'hFFFF;
      end
      default: fpu_out = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one element through LOAD/MUL/ADD; entered and left at a falling edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("mul_mode", 32'(fpu_mode), 32'h4);
    chk("mul_in1", 32'(fpu_in1), 32'(a));
    chk("mul_in2", 32'(fpu_in2), 32'(b));
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("add_mode", 32'(fpu_mode), 32'h1);
    chk("add_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_acc_clear", 32'(out_data), 32'h0);
    chk("hs_cnt_clear", 32'(out_count), 32'h0);
    chk("hs_ovf_clear", 32'(out_ovf), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_mode", 32'(fpu_mode), 32'h0);
    chk("rst_in1", 32'(fpu_in1), 32'h0);
    chk("rst_in2", 32'(fpu_in2), 32'h0);
    rst_n = 1'b1;

    // idle input: nothing changes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_mode", 32'(fpu_mode), 32'h0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
    end

    // two-element vector: 1*2 + 2*3 = 8
    send(16'h3F80, 16'h4000, 1'b0);
    chk("v2_mid_count", 32'(out_count), 32'd1);
    chk("v2_mid_acc", 32'(out_data), 32'h4000);
    chk("v2_mid_out_valid", 32'(out_valid), 32'd0);
    send(16'h4000, 16'h4040, 1'b1);
    chk("v2_out_valid", 32'(out_valid), 32'd1);
    chk("v2_data", 32'(out_data), 32'h4100);
    chk("v2_count", 32'(out_count), 32'd2);
    chk("v2_ovf", 32'(out_ovf), 32'd0);
    chk("v2_done_mode", 32'(fpu_mode), 32'h0);
    handshake();

    // single element 3*4 = 12, then output backpressure
    send(16'h4040, 16'h4080, 1'b1);
    chk("v1_data", 32'(out_data), 32'h4140);
    chk("v1_count", 32'(out_count), 32'd1);
    chk("v1_done_mode", 32'(fpu_mode), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h4140);
      chk("bp_count", 32'(out_count), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_mode", 32'(fpu_mode), 32'h0);
    end
    handshake();

    // overflow: (2^127)^2
    send(16'h7F00, 16'h7F00, 1'b1);
    chk("ovf_flag", 32'(out_ovf), 32'd1);
    chk("ovf_data", 32'(out_data), 32'(OVF_RESULT));
    chk("ovf_out_valid", 32'(out_valid), 32'd1);

    // handshake with input already valid: accept must wait one edge
    in_valid  = 1'b1;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_mode", 32'(fpu_mode), 32'h0);
    chk("b2b_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_ovf_clear", 32'(out_ovf), 32'd0);

    // count saturation: 256 zero elements
    for (int i = 0; i < 256; i++) begin
      send(16'h0000, 16'h0000, (i == 255));
    end
    chk("sat_count", 32'(out_count), 32'hFF);
    chk("sat_data", 32'(out_data), 32'h0);
    chk("sat_ovf", 32'(out_ovf), 32'd0);
    chk("sat_out_valid", 32'(out_valid), 32'd1);
    handshake();

    // reset during ADD of element 1 of 3
    send(16'h3F80, 16'h4000, 1'b0);
    chk("mr_pre_count", 32'(out_count), 32'd1);
    in_valid = 1'b1;
    in_a     = 16'h4000;
    in_b     = 16'h4040;
    in_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_add_mode", 32'(fpu_mode), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'h0);
    chk("mr_count", 32'(out_count), 32'h0);
    chk("mr_ovf", 32'(out_ovf), 32'd0);
    chk("mr_mode", 32'(fpu_mode), 32'h0);
    chk("mr_in1", 32'(fpu_in1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("mr_idle_out_valid", 32'(out_valid), 32'd0);
      chk("mr_idle_in_ready", 32'(in_ready), 32'd1);
    end
    send(16'h3F80, 16'h3F80, 1'b1);
    chk("mr_vec_data", 32'(out_data), 32'h3F80);
    chk("mr_vec_count", 32'(out_count), 32'd1);
    chk("mr_vec_out_valid", 32'(out_valid), 32'd1);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
